// File: rtl/seq_adder_resp_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default operand width.
package seq_adder_resp_pkg;

  localparam int unsigned ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_adder_resp_full_adder.sv
// One-bit full adder used by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_adder_resp.sv
// Bit-serial unsigned adder with valid/ready handshakes: one bit pair per cycle, LSB first.
module seq_adder_resp
  import seq_adder_resp_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             carry,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] xs_q;
  logic [WIDTH-1:0] ys_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic             carry_q;
  logic             fa_s;
  logic             fa_cout;

  full_adder u_fa (
    .a   (xs_q[0]),
    .b   (ys_q[0]),
    .cin (cy_q),
    .s   (fa_s),
    .cout(fa_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            xs_q    <= x;
            ys_q    <= y;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          xs_q  <= xs_q >> 1;
          ys_q  <= ys_q >> 1;
          // Sum bits enter at the MSB, so after WIDTH shifts bit 0 lands at the LSB.
          res_q <= {fa_s, res_q[WIDTH-1:1]};
          cy_q  <= fa_cout;
          if (cnt_q == LAST_BIT) begin
            carry_q <= fa_cout;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign carry     = carry_q;
  assign out       = res_q;

endmodule
